// File: rtl/llc_mem_line_bridge_pkg.sv
// Shared constants and types for the LLC memory-side line/word bridge.
// Line geometry is fixed here; every other file derives its widths from it.
package llc_mem_line_bridge_pkg;

    localparam int WORDS_PER_LINE = 4;
    localparam int BITS_PER_WORD  = 64;
    localparam int ADDR_BITS      = 32;
    localparam int WORD_BYTES     = BITS_PER_WORD / 8;
    localparam int WORD_SHIFT     = $clog2(WORD_BYTES);
    localparam int OFFSET_BITS    = $clog2(WORDS_PER_LINE * WORD_BYTES);
    localparam int LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;
    localparam int IDX_BITS       = $clog2(WORDS_PER_LINE);
    localparam int CNT_BITS       = IDX_BITS + 1;

    typedef logic [LINE_ADDR_BITS-1:0]                    line_addr_t;
    typedef logic [ADDR_BITS-1:0]                         addr_t;
    typedef logic [BITS_PER_WORD-1:0]                     word_t;
    typedef logic [WORDS_PER_LINE-1:0][BITS_PER_WORD-1:0] line_t;
    typedef logic [2:0]                                   hsize_t;
    typedef logic [CNT_BITS-1:0]                          cnt_t;

    // Byte address of word idx inside the line at line address la.
    function automatic addr_t beat_addr(line_addr_t la, logic [IDX_BITS-1:0] idx);
        return {la, {OFFSET_BITS{1'b0}}} + (addr_t'(idx) << WORD_SHIFT);
    endfunction

endpackage

// File: rtl/llc_mem_line_bridge_if.sv
// Bus bundle between the LLC memory channel, the bridge and the word memory port.
// slave = bridge side, master = LLC + memory environment side.
interface llc_mem_line_bridge_if;
    import llc_mem_line_bridge_pkg::*;

    logic       llc_mem_req_valid;
    logic       llc_mem_req_ready;
    logic       llc_mem_req_data_hwrite;
    hsize_t     llc_mem_req_data_hsize;
    logic [1:0] llc_mem_req_data_hprot;
    line_addr_t llc_mem_req_data_addr;
    line_t      llc_mem_req_data_line;

    logic       llc_mem_rsp_valid;
    logic       llc_mem_rsp_ready;
    line_t      llc_mem_rsp_data_line;

    logic       mem_word_req_valid;
    logic       mem_word_req_ready;
    logic       mem_word_req_we;
    addr_t      mem_word_req_addr;
    hsize_t     mem_word_req_hsize;
    logic       mem_word_req_hprot;
    word_t      mem_word_req_wdata;

    logic       mem_word_rsp_valid;
    logic       mem_word_rsp_ready;
    word_t      mem_word_rsp_rdata;

    modport slave (
        input  llc_mem_req_valid, llc_mem_req_data_hwrite, llc_mem_req_data_hsize,
               llc_mem_req_data_hprot, llc_mem_req_data_addr, llc_mem_req_data_line,
               llc_mem_rsp_ready, mem_word_req_ready, mem_word_rsp_valid, mem_word_rsp_rdata,
        output llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_data_line,
               mem_word_req_valid, mem_word_req_we, mem_word_req_addr, mem_word_req_hsize,
               mem_word_req_hprot, mem_word_req_wdata, mem_word_rsp_ready
    );

    modport master (
        output llc_mem_req_valid, llc_mem_req_data_hwrite, llc_mem_req_data_hsize,
               llc_mem_req_data_hprot, llc_mem_req_data_addr, llc_mem_req_data_line,
               llc_mem_rsp_ready, mem_word_req_ready, mem_word_rsp_valid, mem_word_rsp_rdata,
        input  llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_data_line,
               mem_word_req_valid, mem_word_req_we, mem_word_req_addr, mem_word_req_hsize,
               mem_word_req_hprot, mem_word_req_wdata, mem_word_rsp_ready
    );

endinterface

// File: rtl/llc_mem_line_bridge_beat_ctr.sv
// Issue/receive beat counter pair for one line transaction.
// Both saturate at WORDS_PER_LINE so a stray increment can never wrap into a new beat.
module llc_mem_line_bridge_beat_ctr
    import llc_mem_line_bridge_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic issue_inc,
    input  logic recv_inc,
    output cnt_t issued,
    output cnt_t received,
    output logic issue_last,
    output logic issue_done,
    output logic recv_last
);
    localparam cnt_t FULL = cnt_t'(WORDS_PER_LINE);
    localparam cnt_t LAST = cnt_t'(WORDS_PER_LINE - 1);

    cnt_t issued_q, issued_d;
    cnt_t received_q, received_d;

    always_comb begin
        issued_d   = issued_q;
        received_d = received_q;
        if (clr) begin
            issued_d   = '0;
            received_d = '0;
        end else begin
            if (issue_inc && issued_q != FULL) issued_d = issued_q + cnt_t'(1);
            if (recv_inc && received_q != FULL) received_d = received_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q   <= '0;
            received_q <= '0;
        end else begin
            issued_q   <= issued_d;
            received_q <= received_d;
        end
    end

    assign issued     = issued_q;
    assign received   = received_q;
    assign issue_last = (issued_q == LAST);
    assign issue_done = (issued_q == FULL);
    assign recv_last  = (received_q == LAST);

endmodule

// File: rtl/llc_mem_line_bridge.sv
// Memory-side responder: splits LLC line reads/writebacks into word beats and
// reassembles read words into a line for the fill response.
module llc_mem_line_bridge
    import llc_mem_line_bridge_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    llc_mem_line_bridge_if.slave  bus,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, RD, RD_RSP, WR} state_e;

    state_e     state_q, state_d;
    hsize_t     hsize_q, hsize_d;
    logic       hprot_q, hprot_d;
    line_addr_t addr_q, addr_d;
    line_t      line_q, line_d;

    logic req_acc, word_req_vld, issue_inc, recv_inc;
    logic issue_last, issue_done, recv_last;
    cnt_t issued, received;
    logic [IDX_BITS-1:0] issue_idx, recv_idx;

    assign issue_idx    = issued[IDX_BITS-1:0];
    assign recv_idx     = received[IDX_BITS-1:0];
    assign req_acc      = (state_q == IDLE) && bus.llc_mem_req_valid;
    assign word_req_vld = ((state_q == RD) && !issue_done) || (state_q == WR);
    assign issue_inc    = word_req_vld && bus.mem_word_req_ready;
    assign recv_inc     = (state_q == RD) && bus.mem_word_rsp_valid;

    llc_mem_line_bridge_beat_ctr u_beat_ctr (
        .clk        (clk),
        .rst        (rst),
        .clr        (req_acc),
        .issue_inc  (issue_inc),
        .recv_inc   (recv_inc),
        .issued     (issued),
        .received   (received),
        .issue_last (issue_last),
        .issue_done (issue_done),
        .recv_last  (recv_last)
    );

    always_comb begin
        state_d = state_q;
        hsize_d = hsize_q;
        hprot_d = hprot_q;
        addr_d  = addr_q;
        line_d  = line_q;
        unique case (state_q)
            IDLE: begin
                if (req_acc) begin
                    hsize_d = bus.llc_mem_req_data_hsize;
                    hprot_d = bus.llc_mem_req_data_hprot[0];
                    addr_d  = bus.llc_mem_req_data_addr;
                    // Reads start from a clean buffer so nothing from the last line leaks out.
                    line_d  = bus.llc_mem_req_data_hwrite ? bus.llc_mem_req_data_line : '0;
                    state_d = bus.llc_mem_req_data_hwrite ? WR : RD;
                end
            end
            RD: begin
                if (recv_inc) begin
                    line_d[recv_idx] = bus.mem_word_rsp_rdata;
                    if (recv_last) state_d = RD_RSP;
                end
            end
            RD_RSP: begin
                if (bus.llc_mem_rsp_ready) state_d = IDLE;
            end
            WR: begin
                if (issue_inc && issue_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hsize_q <= '0;
            hprot_q <= 1'b0;
            addr_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            hsize_q <= hsize_d;
            hprot_q <= hprot_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    assign bus.llc_mem_req_ready     = (state_q == IDLE);
    assign bus.llc_mem_rsp_valid     = (state_q == RD_RSP);
    assign bus.llc_mem_rsp_data_line = line_q;
    assign bus.mem_word_req_valid    = word_req_vld;
    assign bus.mem_word_req_we       = (state_q == WR);
    assign bus.mem_word_req_addr     = beat_addr(addr_q, issue_idx);
    assign bus.mem_word_req_hsize    = hsize_q;
    assign bus.mem_word_req_hprot    = hprot_q;
    // In RD this word is still zero: its response can only land after it was issued.
    assign bus.mem_word_req_wdata    = line_q[issue_idx];
    assign bus.mem_word_rsp_ready    = (state_q == RD);
    assign busy                      = (state_q != IDLE);

    // Memory returns words in order, never ahead of the matching request.
    always_ff @(posedge clk) begin
        if (!rst && recv_inc) assert (received < issued);
    end

endmodule

// File: tb/tb_llc_mem_line_bridge.sv
// Randomized bench for llc_mem_line_bridge: a word-memory model plus a line-level
// reference (beat list and expected fill line per request) built from plain arithmetic.
module tb_llc_mem_line_bridge;
    import llc_mem_line_bridge_pkg::*;

    typedef logic [255:0] cv_t;
    typedef struct { logic we; addr_t addr; word_t wdata; hsize_t hsize; logic hprot; } beat_t;
    typedef struct { word_t data; int due; } prsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    llc_mem_line_bridge_if bus();

    llc_mem_line_bridge dut (.clk(clk), .rst(rst), .bus(bus.slave), .busy(busy));

    always #5 clk = ~clk;

    beat_t exp_beats[$];
    line_t exp_rsp[$];
    prsp_t pend[$];
    word_t ref_mem[addr_t];
    word_t phys_mem[addr_t];

    int n_chk = 0, n_err = 0;
    int cyc = 0, beats_seen = 0, rsp_seen = 0, rsp_stalls = 0;
    int rdy_mode = 0, lat = 0, rsp_stall = 0;
    line_t last_rsp;

    task automatic chk(input string tag, input cv_t got, input cv_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic word_t rd_ref(addr_t a);
        return ref_mem.exists(a) ? ref_mem[a] : {a, ~a};
    endfunction

    function automatic word_t rd_phys(addr_t a);
        return phys_mem.exists(a) ? phys_mem[a] : {a, ~a};
    endfunction

    // Memory + LLC fill-consumer model, acting on the falling edge.
    logic  tog = 1'b0, rdy = 1'b0;
    int    stall_cnt = 0;
    logic  w_prev_stall = 1'b0, r_prev_stall = 1'b0;
    cv_t   w_prev, w_cur;
    line_t r_prev;
    beat_t e;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            bus.mem_word_req_ready = 1'b0;
            bus.mem_word_rsp_valid = 1'b0;
            bus.mem_word_rsp_rdata = '0;
            bus.llc_mem_rsp_ready  = 1'b0;
            w_prev_stall = 1'b0;
            r_prev_stall = 1'b0;
            stall_cnt    = 0;
        end else begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.mem_word_rsp_valid = 1'b1;
                bus.mem_word_rsp_rdata = pend[0].data;
                if (bus.mem_word_rsp_ready) void'(pend.pop_front());
            end else begin
                bus.mem_word_rsp_valid = 1'b0;
                bus.mem_word_rsp_rdata = '0;
            end

            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       begin tog = ~tog; rdy = tog; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.mem_word_req_ready = rdy;
            w_cur = cv_t'({bus.mem_word_req_we, bus.mem_word_req_addr, bus.mem_word_req_wdata,
                           bus.mem_word_req_hsize, bus.mem_word_req_hprot});
            if (w_prev_stall) begin
                chk("wreq_hold_valid", cv_t'(bus.mem_word_req_valid), cv_t'(1));
                chk("wreq_hold_fields", w_cur, w_prev);
            end
            w_prev_stall = bus.mem_word_req_valid && !rdy;
            w_prev       = w_cur;
            if (bus.mem_word_req_valid && rdy) begin
                beats_seen++;
                if (exp_beats.size() == 0) chk("beat_unexpected", cv_t'(1), cv_t'(0));
                else begin
                    e = exp_beats.pop_front();
                    chk("beat_addr", cv_t'(bus.mem_word_req_addr), cv_t'(e.addr));
                    chk("beat_we", cv_t'(bus.mem_word_req_we), cv_t'(e.we));
                    chk("beat_hsize", cv_t'(bus.mem_word_req_hsize), cv_t'(e.hsize));
                    chk("beat_hprot", cv_t'(bus.mem_word_req_hprot), cv_t'(e.hprot));
                    if (e.we) begin
                        chk("beat_wdata", cv_t'(bus.mem_word_req_wdata), cv_t'(e.wdata));
                        phys_mem[bus.mem_word_req_addr] = bus.mem_word_req_wdata;
                    end else begin
                        pend.push_back('{data: rd_phys(bus.mem_word_req_addr), due: cyc + 1 + lat});
                    end
                end
            end

            if (r_prev_stall) begin
                chk("rsp_hold_valid", cv_t'(bus.llc_mem_rsp_valid), cv_t'(1));
                chk("rsp_hold_line", cv_t'(bus.llc_mem_rsp_data_line), cv_t'(r_prev));
            end
            if (bus.llc_mem_rsp_valid) begin
                if (stall_cnt < rsp_stall) begin
                    bus.llc_mem_rsp_ready = 1'b0;
                    stall_cnt++;
                    rsp_stalls++;
                    r_prev_stall = 1'b1;
                    r_prev       = bus.llc_mem_rsp_data_line;
                end else begin
                    bus.llc_mem_rsp_ready = 1'b1;
                    r_prev_stall = 1'b0;
                    stall_cnt    = 0;
                    rsp_seen++;
                    last_rsp = bus.llc_mem_rsp_data_line;
                    if (exp_rsp.size() == 0) chk("rsp_unexpected", cv_t'(1), cv_t'(0));
                    else chk("rsp_line", cv_t'(bus.llc_mem_rsp_data_line), cv_t'(exp_rsp.pop_front()));
                end
            end else begin
                bus.llc_mem_rsp_ready = 1'b0;
                r_prev_stall = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a line request becomes WORDS_PER_LINE consecutive word beats.
    task automatic model(input logic hw, input line_addr_t a, input line_t ln,
                         input hsize_t hs, input logic [1:0] hp);
        line_t exp_ln;
        addr_t ba;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            ba = addr_t'(a) * addr_t'(WORDS_PER_LINE * BITS_PER_WORD / 8) + addr_t'(i * (BITS_PER_WORD / 8));
            if (hw) begin
                exp_beats.push_back('{we: 1'b1, addr: ba, wdata: ln[i], hsize: hs, hprot: hp[0]});
                ref_mem[ba] = ln[i];
            end else begin
                exp_beats.push_back('{we: 1'b0, addr: ba, wdata: '0, hsize: hs, hprot: hp[0]});
                exp_ln[i] = rd_ref(ba);
            end
        end
        if (!hw) exp_rsp.push_back(exp_ln);
    endtask

    task automatic send(input logic hw, input line_addr_t a, input line_t ln,
                        input hsize_t hs, input logic [1:0] hp);
        int t = 0;
        bus.llc_mem_req_valid       = 1'b1;
        bus.llc_mem_req_data_hwrite = hw;
        bus.llc_mem_req_data_addr   = a;
        bus.llc_mem_req_data_line   = ln;
        bus.llc_mem_req_data_hsize  = hs;
        bus.llc_mem_req_data_hprot  = hp;
        while (!bus.llc_mem_req_ready && t < 300) begin
            chk("busy_while_not_ready", cv_t'(busy), cv_t'(1));
            tick();
            t++;
        end
        if (t >= 300) begin
            chk("req_accept_timeout", cv_t'(0), cv_t'(1));
        end else begin
            chk("prev_rsp_done_at_accept", cv_t'(exp_rsp.size()), cv_t'(0));
            model(hw, a, ln, hs, hp);
            tick();
        end
        bus.llc_mem_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || exp_beats.size() != 0 || exp_rsp.size() != 0) && t < 1000) begin
            tick();
            t++;
        end
        if (t >= 1000) chk("idle_timeout", cv_t'(0), cv_t'(1));
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < WORDS_PER_LINE; i++) l[i] = {$urandom, $urandom};
        return l;
    endfunction

    initial begin
        int b0, r0, s0, t;
        bus.llc_mem_req_valid       = 1'b0;
        bus.llc_mem_req_data_hwrite = 1'b0;
        bus.llc_mem_req_data_hsize  = '0;
        bus.llc_mem_req_data_hprot  = '0;
        bus.llc_mem_req_data_addr   = '0;
        bus.llc_mem_req_data_line   = '0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_req_ready", cv_t'(bus.llc_mem_req_ready), cv_t'(1));
        chk("rst_rsp_valid", cv_t'(bus.llc_mem_rsp_valid), cv_t'(0));
        chk("rst_wreq_valid", cv_t'(bus.mem_word_req_valid), cv_t'(0));
        chk("rst_wrsp_ready", cv_t'(bus.mem_word_rsp_ready), cv_t'(0));
        chk("rst_busy", cv_t'(busy), cv_t'(0));
        rst = 1'b0;
        tick();

        // Read with zero-latency memory, known words 0xA0+i.
        for (int i = 0; i < 4; i++) begin
            ref_mem[32'h2000 + 32'(i * 8)]  = 64'hA0 + 64'(i);
            phys_mem[32'h2000 + 32'(i * 8)] = 64'hA0 + 64'(i);
        end
        rdy_mode = 0; lat = 0; rsp_stall = 0;
        send(1'b0, line_addr_t'(27'h100), '0, 3'd3, 2'b01);
        wait_idle();
        chk("rd_known_line", cv_t'(last_rsp), cv_t'({64'hA3, 64'hA2, 64'hA1, 64'hA0}));

        // Writeback: four posted beats, no fill.
        r0 = rsp_seen;
        send(1'b1, line_addr_t'(27'h1), {64'd4, 64'd3, 64'd2, 64'd1}, 3'd3, 2'b10);
        wait_idle();
        chk("wb_no_rsp", cv_t'(rsp_seen - r0), cv_t'(0));
        chk("wb_word0", cv_t'(rd_phys(32'h20)), cv_t'(1));
        chk("wb_word3", cv_t'(rd_phys(32'h38)), cv_t'(4));
        chk("wb_ready_after", cv_t'(bus.llc_mem_req_ready), cv_t'(1));

        // Backpressure on both sides.
        rdy_mode = 1; lat = 1; rsp_stall = 5;
        b0 = beats_seen; s0 = rsp_stalls;
        send(1'b0, line_addr_t'(27'h200), '0, 3'd2, 2'b11);
        wait_idle();
        chk("bp_beats", cv_t'(beats_seen - b0), cv_t'(4));
        chk("bp_rsp_stalls", cv_t'(rsp_stalls - s0), cv_t'(5));

        // Overlapped issue/receive with 3-cycle memory latency.
        rdy_mode = 0; lat = 3; rsp_stall = 0;
        b0 = beats_seen;
        send(1'b0, line_addr_t'(27'h1), '0, 3'd3, 2'b00);
        wait_idle();
        chk("ovl_beats", cv_t'(beats_seen - b0), cv_t'(4));
        chk("ovl_line", cv_t'(last_rsp), cv_t'({64'd4, 64'd3, 64'd2, 64'd1}));

        // Reset after two of four read beats.
        lat = 20;
        b0 = beats_seen; r0 = rsp_seen; t = 0;
        send(1'b0, line_addr_t'(27'h100), '0, 3'd3, 2'b01);
        while (beats_seen - b0 < 2 && t < 200) begin tick(); t++; end
        chk("rst_mid_reached_2", cv_t'(beats_seen - b0), cv_t'(2));
        rst = 1'b1;
        exp_beats.delete(); exp_rsp.delete(); pend.delete();
        tick();
        chk("rst_mid_wreq_valid", cv_t'(bus.mem_word_req_valid), cv_t'(0));
        chk("rst_mid_rsp_valid", cv_t'(bus.llc_mem_rsp_valid), cv_t'(0));
        chk("rst_mid_req_ready", cv_t'(bus.llc_mem_req_ready), cv_t'(1));
        rst = 1'b0;
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            ref_mem[32'h2000 + 32'(i * 8)]  = 64'hB0 + 64'(i);
            phys_mem[32'h2000 + 32'(i * 8)] = 64'hB0 + 64'(i);
        end
        send(1'b0, line_addr_t'(27'h100), '0, 3'd3, 2'b01);
        wait_idle();
        chk("rst_mid_no_stale_rsp", cv_t'(rsp_seen - r0), cv_t'(1));
        chk("rst_mid_fresh_line", cv_t'(last_rsp), cv_t'({64'hB3, 64'hB2, 64'hB1, 64'hB0}));

        // Back-to-back held-valid: read, writeback, read of the same line.
        lat = 2; rsp_stall = 2;
        send(1'b0, line_addr_t'(27'h300), '0, 3'd3, 2'b01);
        send(1'b1, line_addr_t'(27'h300), rand_line(), 3'd3, 2'b01);
        send(1'b0, line_addr_t'(27'h300), '0, 3'd3, 2'b01);
        wait_idle();

        // Random traffic over a small address pool so reads observe earlier writebacks.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                wait_idle();
                rdy_mode  = $urandom_range(0, 2);
                lat       = $urandom_range(0, 4);
                rsp_stall = $urandom_range(0, 3);
            end
            send(1'($urandom_range(0, 1)), line_addr_t'(27'h40 + 27'($urandom_range(0, 7))),
                 rand_line(), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end
        wait_idle();
        chk("end_idle_ready", cv_t'(bus.llc_mem_req_ready), cv_t'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/llc_mem_line_bridge.md
Name: llc_mem_line_bridge

Overview:
- Memory-side responder for the LLC memory channel.
- Accepts line-granular llc_mem_req transactions (reads and writebacks) and splits each into WORDS_PER_LINE word beats on a simple valid/ready word-memory port.
- For reads, collects the word responses into a line and returns it on llc_mem_rsp. Writebacks are posted and return nothing.
- Sits between llc_core's memory interface and the SoC memory/DMA fabric.

Parameters:
- WORDS_PER_LINE, 4, words per cache line; power of two, >=2.
- BITS_PER_WORD, 64, word width in bits; line width = WORDS_PER_LINE*BITS_PER_WORD.
- ADDR_BITS, 32, physical byte-address width.
- LINE_ADDR_BITS, 27, line-address width = ADDR_BITS - log2(WORDS_PER_LINE*BITS_PER_WORD/8).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- llc_mem_req_valid  in  1  LLC memory request valid
- llc_mem_req_ready  out  1  bridge can accept a request
- llc_mem_req_data_hwrite  in  1  1=writeback, 0=line fill
- llc_mem_req_data_hsize  in  3  transfer size; forwarded per beat, does not change beat count
- llc_mem_req_data_hprot  in  2  protection; bit0 forwarded
- llc_mem_req_data_addr  in  LINE_ADDR_BITS  line address
- llc_mem_req_data_line  in  line width  writeback data
- llc_mem_rsp_valid  out  1  fill data valid
- llc_mem_rsp_ready  in  1  LLC accepts fill
- llc_mem_rsp_data_line  out  line width  fill data
- mem_word_req_valid  out  1  word request valid
- mem_word_req_ready  in  1  memory accepts word request
- mem_word_req_we  out  1  write enable
- mem_word_req_addr  out  ADDR_BITS  byte address of beat
- mem_word_req_hsize  out  3  copy of latched hsize
- mem_word_req_hprot  out  1  copy of latched hprot[0]
- mem_word_req_wdata  out  BITS_PER_WORD  write data
- mem_word_rsp_valid  in  1  read data valid (in order)
- mem_word_rsp_ready  out  1  bridge accepts read data
- mem_word_rsp_rdata  in  BITS_PER_WORD  read data
- busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous and active-high on clk. On reset:
  - state=IDLE; issue and receive counters = 0; line buffer = 0.
  - All valid outputs = 0; llc_mem_req_ready=1 (from the next cycle).
  - Reset mid-transaction abandons it silently: no rsp is emitted and no partial beats resume.
- States: IDLE, RD, RD_RSP, WR.
- IDLE:
  - llc_mem_req_ready=1.
  - On valid&ready, latch hwrite, hsize, hprot[0], addr and line; clear counters.
  - Next state is WR if hwrite=1, else RD. No combinational valid->ready path.
- Beat addressing:
  - Beat i address = {addr, zeros of offset width} + i*(BITS_PER_WORD/8).
  - Word i occupies line bits [i*BITS_PER_WORD +: BITS_PER_WORD].
- RD:
  - mem_word_req_valid=1 while issued < WORDS_PER_LINE; we=0.
  - mem_word_rsp_ready=1 throughout RD.
  - Issue and receive advance independently. A request accept and a response accept in the same cycle both count.
  - received <= issued at all times; a response with received==issued is a protocol error (assertion).
  - The response for beat k writes line-buffer word k.
  - When response WORDS_PER_LINE-1 is accepted, go to RD_RSP the next cycle.
- RD_RSP:
  - llc_mem_rsp_valid=1 and data=line buffer, held stable until llc_mem_rsp_ready.
  - On accept, go to IDLE; llc_mem_req_ready=1 in the following cycle.
- WR:
  - mem_word_req_valid=1, we=1, wdata=latched word[issued].
  - On the accept of beat WORDS_PER_LINE-1, go to IDLE. There is no llc_mem_rsp.
- mem_word_req_* stays stable while valid=1 and ready=0.
- mem_word_rsp_ready=0 outside RD; responses arriving there stall.
- Counters are log2(WORDS_PER_LINE)+1 bits wide and saturate at WORDS_PER_LINE; no wrap.
- Throughput:
  - Best-case read latency is 1 (accept) + WORDS_PER_LINE issue cycles + memory latency + 1 (rsp).
  - A new request is accepted no earlier than the cycle after returning to IDLE.

Decomposition:
- Shared package (spandex_consts/spandex_types): WORDS_PER_LINE, BITS_PER_WORD, ADDR_BITS, line_addr_t, line_t, hsize_t, word_t.
- Bridge state enum defined locally.
- One natural sub-module: llc_mem_line_bridge_beat_ctr, holding the issue/receive counter pair with saturation and done flags.

Test Plan:
- Read, zero-latency memory: addr=0x100, memory returns word i = 0xA0+i -> beat addrs 0x2000,0x2008,0x2010,0x2018; llc_mem_rsp line = {0xA3,0xA2,0xA1,0xA0}, valid held until ready.
- Writeback: hwrite=1, addr=0x1, line={4,3,2,1} -> four we=1 beats at 0x20,0x28,0x30,0x38 with wdata 1,2,3,4; no llc_mem_rsp; ready=1 after last beat.
- Backpressure: mem_word_req_ready toggles 1/0 and llc_mem_rsp_ready held low 5 cycles -> beat fields stable while stalled; rsp valid/data stable 5 cycles; exactly 4 beats.
- Overlap: responses arrive 3 cycles after each issue while issuing continues -> counters advance concurrently; correct line returned; no assertion.
- Reset mid-read after 2 of 4 beats -> next cycle all valids=0, llc_mem_req_ready=1; a following read completes normally with no stale words.
- Back-to-back requests held valid: read then writeback -> second request is accepted only after the read rsp handshake; llc_mem_req_ready=0 during busy.
